// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU completions and load-queue returns onto one registered
// writeback port. Define WB_LOAD_BYPASS_EN to let loads skip an empty, uncontested load queue.
module writeback_arbiter #(
   parameter int unsigned NUM_WARPS      = 4,
   parameter int unsigned LQ_DEPTH       = 4,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned WARP_SIZE      = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned WARP_ID_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   parameter int unsigned CNT_WIDTH      = $clog2(LQ_DEPTH) + 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            alu_valid,
   output logic                            alu_ready,
   input  logic [WARP_ID_WIDTH-1:0]        alu_warp_id,
   input  logic [REG_ADDR_WIDTH-1:0]       alu_rd,
   input  logic                            alu_reg_write,
   input  logic [WARP_SIZE-1:0]            alu_mask,
   input  logic [WARP_SIZE*DATA_WIDTH-1:0] alu_result,
   input  logic                            ld_valid,
   output logic                            ld_ready,
   input  logic [WARP_ID_WIDTH-1:0]        ld_warp_id,
   input  logic [REG_ADDR_WIDTH-1:0]       ld_rd,
   input  logic [WARP_SIZE-1:0]            ld_mask,
   input  logic [WARP_SIZE*DATA_WIDTH-1:0] ld_data,
   output logic                            wb_valid,
   output logic [WARP_ID_WIDTH-1:0]        wb_warp_id,
   output logic [REG_ADDR_WIDTH-1:0]       wb_rd,
   output logic                            wb_reg_write,
   output logic [WARP_SIZE-1:0]            wb_mask,
   output logic [WARP_SIZE*DATA_WIDTH-1:0] wb_result,
   output logic [CNT_WIDTH-1:0]            lq_count
);

   localparam int unsigned PTR_WIDTH    = $clog2(LQ_DEPTH);
   localparam int unsigned STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_WIDTH-1:0]    LQ_FULL    = CNT_WIDTH'(LQ_DEPTH);
   localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

   logic [WARP_ID_WIDTH-1:0]        lq_warp [LQ_DEPTH];
   logic [REG_ADDR_WIDTH-1:0]       lq_rd   [LQ_DEPTH];
   logic [WARP_SIZE-1:0]            lq_mask [LQ_DEPTH];
   logic [WARP_SIZE*DATA_WIDTH-1:0] lq_data [LQ_DEPTH];

   logic [PTR_WIDTH-1:0]    wr_ptr;
   logic [PTR_WIDTH-1:0]    rd_ptr;
   logic [STARVE_WIDTH-1:0] starve_cnt;
   logic                    lq_nonempty;
   logic                    lq_full;
   logic                    lq_grant;
   logic                    lq_push;
   logic                    alu_fire;

   assign lq_nonempty = (lq_count != '0);
   assign lq_full     = (lq_count == LQ_FULL);
   assign lq_grant    = lq_nonempty && (!alu_valid || lq_full || (starve_cnt == STARVE_MAX));
   assign alu_ready   = !lq_grant;
   assign alu_fire    = alu_valid && alu_ready;
   // ld_ready looks only at the registered count, so a same-cycle pop never frees a slot early
   assign ld_ready    = !lq_full;

`ifdef WB_LOAD_BYPASS_EN
   logic ld_bypass;
   assign ld_bypass = ld_valid && !lq_nonempty && !alu_valid;
   assign lq_push   = ld_valid && ld_ready && !ld_bypass;
`else
   assign lq_push   = ld_valid && ld_ready;
`endif

   always_ff @(posedge clk) begin
      if (lq_push) begin
         lq_warp[wr_ptr] <= ld_warp_id;
         lq_rd[wr_ptr]   <= ld_rd;
         lq_mask[wr_ptr] <= ld_mask;
         lq_data[wr_ptr] <= ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         lq_count <= '0;
      end else begin
         if (lq_push) wr_ptr <= wr_ptr + 1'b1;
         if (lq_grant) rd_ptr <= rd_ptr + 1'b1;
         unique case ({lq_push, lq_grant})
            2'b10:   lq_count <= lq_count + 1'b1;
            2'b01:   lq_count <= lq_count - 1'b1;
            default: lq_count <= lq_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (lq_grant || !lq_nonempty) begin
         starve_cnt <= '0;
      end else if (alu_fire && (starve_cnt != STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Payload holds its last value when idle; only valid and reg_write are forced low
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid     <= 1'b0;
         wb_warp_id   <= '0;
         wb_rd        <= '0;
         wb_reg_write <= 1'b0;
         wb_mask      <= '0;
         wb_result    <= '0;
      end else begin
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         if (lq_grant) begin
            wb_valid     <= 1'b1;
            wb_warp_id   <= lq_warp[rd_ptr];
            wb_rd        <= lq_rd[rd_ptr];
            wb_reg_write <= (lq_rd[rd_ptr] != '0);
            wb_mask      <= lq_mask[rd_ptr];
            wb_result    <= lq_data[rd_ptr];
         end else if (alu_fire) begin
            wb_valid     <= 1'b1;
            wb_warp_id   <= alu_warp_id;
            wb_rd        <= alu_rd;
            wb_reg_write <= alu_reg_write && (alu_rd != '0);
            wb_mask      <= alu_mask;
            wb_result    <= alu_result;
`ifdef WB_LOAD_BYPASS_EN
         end else if (ld_bypass) begin
            wb_valid     <= 1'b1;
            wb_warp_id   <= ld_warp_id;
            wb_rd        <= ld_rd;
            wb_reg_write <= (ld_rd != '0);
            wb_mask      <= ld_mask;
            wb_result    <= ld_data;
`endif
         end
      end
   end

endmodule
